// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
package reg_bank_write_arbiter_pkg;

  // Widest bank this helper set supports (NREG up to 16).
  localparam int MAX_NREG = 16;
  localparam int MAX_AW   = 4;

  // Arbiter modes: normal round-robin arbitration, or whole-bank clear sweep.
  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Index width for n entries; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot decode of a register address; callers truncate to their bank size.
  function automatic logic [MAX_NREG-1:0] onehot(input logic [MAX_AW-1:0] addr);
    return {{(MAX_NREG-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_rr_priority_picker.sv
// Round-robin priority picker: finds the first set request strictly after
// the pointer, searching upward with wrap-around. Purely combinational.
module rr_priority_picker
  import reg_bank_write_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = addr_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_winner,
  output logic            o_valid
);

  // Requests rotated so that bit 0 is requester (ptr+1) mod NREQ.
  logic [NREQ-1:0] w_rot;

  assign w_rot = NREQ'({i_req, i_req} >> (int'(i_ptr) + 1));

  // Lowest set bit of the rotated vector is the winner; map it back.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!o_valid && w_rot[j[PW-1:0]]) begin
        o_valid  = 1'b1;
        o_winner = PW'((int'(i_ptr) + 1 + j) % NREQ);
      end
    end
  end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Shares the single write path of a register bank between NREQ requesters.
// Round-robin arbitration issues at most one write per cycle; a bank_clr
// pulse starts a sweep that clears every register, one per cycle.
//
// Handshake: a requester raises req[i] with its addr/data/clr and holds them
// stable until gnt[i] is seen; it drops req[i] during the gnt cycle. A req
// still high at the following edge counts as a new request. Grants to
// different requesters may follow each other on consecutive cycles.
module reg_bank_write_arbiter
  import reg_bank_write_arbiter_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int NREG = 4,
  parameter  int W    = 8,
  localparam int AW   = addr_width(NREG),
  localparam int PW   = addr_width(NREQ)
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ-1:0]   req_clr,
  input  logic              bank_clr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREG-1:0]   reg_en,
  output logic              reg_clr,
  output logic [W-1:0]      reg_d,
  output logic              busy,
  output logic              dbg_state
);

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [AW-1:0]   r_idx;
  logic [NREQ-1:0] r_gnt;
  logic [NREG-1:0] r_reg_en;
  logic            r_reg_clr;
  logic [W-1:0]    r_reg_d;
  logic            r_busy;

  state_t          w_state_nxt;
  logic [PW-1:0]   w_ptr_nxt;
  logic [AW-1:0]   w_idx_nxt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [NREG-1:0] w_en_nxt;
  logic            w_clr_nxt;
  logic [W-1:0]    w_d_nxt;
  logic            w_busy_nxt;

  logic [PW-1:0]   w_winner;
  logic            w_valid;
  logic [AW-1:0]   w_addr_arr [NREQ];
  logic [W-1:0]    w_data_arr [NREQ];

  // Unpack the flat per-requester address and data buses.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_arr[g] = req_addr[g*AW +: AW];
    assign w_data_arr[g] = req_data[g*W +: W];
  end

  rr_priority_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  // Next state and next registered outputs; reg_d holds when nothing is written.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_gnt_nxt   = '0;
    w_en_nxt    = '0;
    w_clr_nxt   = 1'b0;
    w_d_nxt     = r_reg_d;
    w_busy_nxt  = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (bank_clr) begin
          // Sweep wins over pending requests, which simply keep waiting.
          w_state_nxt = ST_SWEEP;
          w_idx_nxt   = '0;
        end else if (w_valid) begin
          w_gnt_nxt = NREQ'(1) << w_winner;
          w_en_nxt  = NREG'(onehot(MAX_AW'(w_addr_arr[w_winner])));
          w_clr_nxt = req_clr[w_winner];
          w_d_nxt   = req_clr[w_winner] ? '0 : w_data_arr[w_winner];
          w_ptr_nxt = w_winner;
        end
      end
      ST_SWEEP: begin
        // bank_clr is ignored here; the pointer is left alone.
        w_en_nxt   = NREG'(onehot(MAX_AW'(r_idx)));
        w_clr_nxt  = 1'b1;
        w_d_nxt    = '0;
        w_busy_nxt = 1'b1;
        w_idx_nxt  = r_idx + 1'b1;
        if (r_idx == AW'(NREG - 1)) begin
          w_state_nxt = ST_ARB;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // State and output registers; CLR aborts any sweep in progress.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state   <= ST_ARB;
      r_ptr     <= PW'(NREQ - 1);
      r_idx     <= '0;
      r_gnt     <= '0;
      r_reg_en  <= '0;
      r_reg_clr <= 1'b0;
      r_reg_d   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_idx     <= w_idx_nxt;
      r_gnt     <= w_gnt_nxt;
      r_reg_en  <= w_en_nxt;
      r_reg_clr <= w_clr_nxt;
      r_reg_d   <= w_d_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign reg_en    = r_reg_en;
  assign reg_clr   = r_reg_clr;
  assign reg_d     = r_reg_d;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench for reg_bank_write_arbiter: directed scenarios with literal
// expectations, then randomized requesters, all checked every cycle against
// a cycle-level behavioural model.
module tb_reg_bank_write_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 4;
  localparam int W    = 8;
  localparam int AW   = 2;
  localparam int OW   = NREQ + NREG + 1 + W + 1 + 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic CLR;
  always #5 CLK = ~CLK;

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*W-1:0]  req_data;
  logic [NREQ-1:0]    req_clr;
  logic               bank_clr;
  logic [NREQ-1:0]    gnt;
  logic [NREG-1:0]    reg_en;
  logic               reg_clr;
  logic [W-1:0]       reg_d;
  logic               busy;
  logic               dbg_state;

  reg_bank_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .W(W)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_clr   (req_clr),
    .bank_clr  (bank_clr),
    .gnt       (gnt),
    .reg_en    (reg_en),
    .reg_clr   (reg_clr),
    .reg_d     (reg_d),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  int              m_ptr  = NREQ - 1;
  int              m_left = 0;
  int              m_pos  = 0;
  int              m_win;
  int              m_cand;
  logic [NREQ-1:0] e_gnt   = '0;
  logic [NREG-1:0] e_en    = '0;
  logic            e_clr   = 1'b0;
  logic [W-1:0]    e_d     = '0;
  logic            e_busy  = 1'b0;
  logic            e_state = 1'b0;
  logic [W-1:0]    m_bank [NREG];
  logic [OW-1:0]   exp_q [$];

  initial begin
    for (int i = 0; i < NREG; i++) m_bank[i] = '0;
  end

  always @(posedge CLK) begin
    // The bank absorbs whatever write was presented during the cycle just ended.
    for (int i = 0; i < NREG; i++) begin
      if (e_en[i]) m_bank[i] = e_clr ? '0 : e_d;
    end
    e_gnt  = '0;
    e_en   = '0;
    e_clr  = 1'b0;
    e_busy = 1'b0;
    if (CLR) begin
      m_ptr   = NREQ - 1;
      m_left  = 0;
      m_pos   = 0;
      e_d     = '0;
      e_state = 1'b0;
    end else if (m_left > 0) begin
      e_en    = NREG'(1) << m_pos;
      e_clr   = 1'b1;
      e_d     = '0;
      e_busy  = 1'b1;
      m_pos   = m_pos + 1;
      m_left  = m_left - 1;
      e_state = (m_left > 0);
    end else if (bank_clr) begin
      m_left  = NREG;
      m_pos   = 0;
      e_state = 1'b1;
    end else begin
      e_state = 1'b0;
      m_win   = -1;
      for (int k = 1; k <= NREQ; k++) begin
        m_cand = (m_ptr + k) % NREQ;
        if (m_win < 0 && req[m_cand]) m_win = m_cand;
      end
      if (m_win >= 0) begin
        e_gnt = NREQ'(1) << m_win;
        e_en  = NREG'(1) << req_addr[m_win*AW +: AW];
        e_clr = req_clr[m_win];
        e_d   = req_clr[m_win] ? '0 : req_data[m_win*W +: W];
        m_ptr = m_win;
      end
    end
    exp_q.push_back({e_gnt, e_en, e_clr, e_d, e_busy, e_state});
  end

  // ---------------- scoreboard: every cycle ----------------
  logic [OW-1:0] cmp_exp;
  logic [OW-1:0] cmp_act;
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      cmp_exp = exp_q.pop_front();
      cmp_act = {gnt, reg_en, reg_clr, reg_d, busy, dbg_state};
      checks++;
      if (cmp_act !== cmp_exp) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got=%h exp=%h (gnt,en,clr,d,busy,state)",
                 $time, cmp_act, cmp_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic set_req(input int i, input int addr, input logic [W-1:0] data, input logic clr);
    req[i]                = 1'b1;
    req_addr[i*AW +: AW]  = AW'(addr);
    req_data[i*W +: W]    = data;
    req_clr[i]            = clr;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    CLR      = 1'b1;
    req      = '1;
    req_addr = '0;
    req_data = '0;
    req_clr  = '0;
    bank_clr = 1'b0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_en", 32'(reg_en), 32'h0);
    check("rst_clr", 32'(reg_clr), 32'h0);
    check("rst_d", 32'(reg_d), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);

    // All requesters held high: grants rotate starting at requester 0.
    CLR = 1'b0;
    tick(); check("rr_gnt0", 32'(gnt), 32'h1);
    tick(); check("rr_gnt1", 32'(gnt), 32'h2);
    tick(); check("rr_gnt2", 32'(gnt), 32'h4);
    tick(); check("rr_gnt3", 32'(gnt), 32'h8);
    tick(); check("rr_gnt4", 32'(gnt), 32'h1);
    req = '0;
    tick();

    // Single write.
    set_req(1, 2, 8'hA5, 1'b0);
    tick();
    check("wr_gnt", 32'(gnt), 32'h2);
    check("wr_en", 32'(reg_en), 32'h4);
    check("wr_clr", 32'(reg_clr), 32'h0);
    check("wr_d", 32'(reg_d), 32'hA5);
    req = '0;
    tick();
    check("wr_bank2", 32'(m_bank[2]), 32'hA5);

    // Requester-issued clear.
    set_req(2, 3, 8'hFF, 1'b1);
    tick();
    check("rc_gnt", 32'(gnt), 32'h4);
    check("rc_en", 32'(reg_en), 32'h8);
    check("rc_clr", 32'(reg_clr), 32'h1);
    check("rc_d", 32'(reg_d), 32'h00);
    req = '0;
    req_clr = '0;
    tick();

    // Sweep with a pending request; a second bank_clr mid-sweep is ignored.
    set_req(0, 1, 8'h5A, 1'b0);
    bank_clr = 1'b1;
    tick();
    check("sw_start_gnt", 32'(gnt), 32'h0);
    check("sw_start_busy", 32'(busy), 32'h0);
    check("sw_start_state", 32'(dbg_state), 32'h1);
    for (int i = 0; i < NREG; i++) begin
      bank_clr = (i == 1);
      tick();
      check("sw_busy", 32'(busy), 32'h1);
      check("sw_en", 32'(reg_en), 32'h1 << i);
      check("sw_clr", 32'(reg_clr), 32'h1);
      check("sw_d", 32'(reg_d), 32'h0);
      check("sw_gnt", 32'(gnt), 32'h0);
    end
    bank_clr = 1'b0;
    tick();
    check("sw_after_gnt", 32'(gnt), 32'h1);
    check("sw_after_en", 32'(reg_en), 32'h2);
    check("sw_after_busy", 32'(busy), 32'h0);
    for (int i = 0; i < NREG; i++) check("sw_bank_zero", 32'(m_bank[i]), 32'h0);
    req = '0;
    tick();
    check("sw_bank1", 32'(m_bank[1]), 32'h5A);

    // Reset in the middle of a sweep.
    bank_clr = 1'b1;
    tick();
    bank_clr = 1'b0;
    tick();
    tick();
    check("mid_en", 32'(reg_en), 32'h2);
    CLR = 1'b1;
    set_req(3, 0, 8'h33, 1'b0);
    tick();
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_en", 32'(reg_en), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'h0);
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    CLR = 1'b0;
    tick();
    check("mid_gnt3", 32'(gnt), 32'h8);
    check("mid_gnt3_en", 32'(reg_en), 32'h1);
    check("mid_gnt3_d", 32'(reg_d), 32'h33);
    req = '0;
    tick();

    // Randomized requesters following the handshake.
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, int'($urandom_range(0, NREG - 1)), W'($urandom),
                  ($urandom_range(0, 3) == 0));
        end
      end
      bank_clr = ($urandom_range(0, 39) == 0);
      CLR      = ($urandom_range(0, 199) == 0);
      tick();
    end
    req      = '0;
    bank_clr = 1'b0;
    CLR      = 1'b0;
    tick();
    tick();
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
